// File: rtl/retire_unit_if.sv
// Commit bundle from the ROB into the retire unit.
// Handshake: the ROB holds cmt_valid_i and all slot fields stable for the
// cycle; the bundle is consumed on a rising edge where cmt_ready_o is high and
// cmt_valid_i[0] is high. Slot 0 is oldest, and slot 1 is only valid when
// slot 0 is valid. cmt_ready_o depends only on internal state, never on the
// bundle contents.
interface retire_unit_if #(
   parameter int CMT_W   = 2,
   parameter int PREG_W  = 6,
   parameter int AREG_W  = 5,
   parameter int ECODE_W = 6
);
   logic [CMT_W-1:0]               cmt_valid_i;
   logic                           cmt_ready_o;
   logic [CMT_W-1:0][31:0]         cmt_pc_i;
   logic [CMT_W-1:0]               cmt_dst_valid_i;
   logic [CMT_W-1:0][AREG_W-1:0]   cmt_areg_i;
   logic [CMT_W-1:0][PREG_W-1:0]   cmt_preg_i;
   logic [CMT_W-1:0][PREG_W-1:0]   cmt_old_preg_i;
   logic [CMT_W-1:0]               cmt_excp_i;
   logic [CMT_W-1:0][ECODE_W-1:0]  cmt_ecode_i;
   logic [CMT_W-1:0]               cmt_redirect_i;
   logic [CMT_W-1:0][31:0]         cmt_target_i;
   logic [CMT_W-1:0]               cmt_flush_i;
   logic [CMT_W-1:0]               cmt_idle_i;
   logic [CMT_W-1:0]               cmt_is_br_i;

   modport master (
      output cmt_valid_i, cmt_pc_i, cmt_dst_valid_i, cmt_areg_i, cmt_preg_i,
             cmt_old_preg_i, cmt_excp_i, cmt_ecode_i, cmt_redirect_i,
             cmt_target_i, cmt_flush_i, cmt_idle_i, cmt_is_br_i,
      input  cmt_ready_o
   );

   modport slave (
      input  cmt_valid_i, cmt_pc_i, cmt_dst_valid_i, cmt_areg_i, cmt_preg_i,
             cmt_old_preg_i, cmt_excp_i, cmt_ecode_i, cmt_redirect_i,
             cmt_target_i, cmt_flush_i, cmt_idle_i, cmt_is_br_i,
      output cmt_ready_o
   );
endinterface

// File: rtl/retire_unit.sv
// Retire unit: retires up to CMT_W instructions per cycle from the ROB,
// updates the architectural RAT, frees old physical registers, trains the
// BPU and turns the first terminating slot into a one-cycle pipeline flush
// (optionally followed by IDLE until an interrupt arrives).
module retire_unit #(
   parameter int CMT_W   = 2,
   parameter int PREG_W  = 6,
   parameter int AREG_W  = 5,
   parameter int ECODE_W = 6
) (
   input  logic                          clk,
   input  logic                          a_rst,
   retire_unit_if.slave                  cmt,
   input  logic [31:0]                   eentry_i,
   input  logic                          intr_i,
   output logic [CMT_W-1:0]              arat_we_o,
   output logic [CMT_W-1:0][AREG_W-1:0]  arat_areg_o,
   output logic [CMT_W-1:0][PREG_W-1:0]  arat_preg_o,
   output logic [CMT_W-1:0]              free_valid_o,
   output logic [CMT_W-1:0][PREG_W-1:0]  free_preg_o,
   output logic                          bpu_upd_valid_o,
   output logic [31:0]                   bpu_upd_pc_o,
   output logic [31:0]                   bpu_upd_target_o,
   output logic                          bpu_upd_miss_o,
   output logic                          flush_o,
   output logic                          redirect_o,
   output logic [31:0]                   redirect_pc_o,
   output logic                          excp_valid_o,
   output logic [ECODE_W-1:0]            excp_ecode_o,
   output logic [31:0]                   excp_pc_o,
   output logic                          idle_o,
   output logic [31:0]                   retire_cnt_o,
   output logic [1:0]                    dbg_state
);

   typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, IDLE = 2'd2} state_t;

   state_t              state_q, state_d;
   logic                accept;
   logic                ready;
   logic                stop;
   logic [CMT_W-1:0]    retired;
   logic [31:0]         ret_sum;
   logic                hit_term, hit_excp, hit_idle;
   logic [ECODE_W-1:0]  hit_ecode;
   logic [31:0]         hit_pc, hit_tgt;
   logic                br_found;
   logic [31:0]         br_pc, br_tgt;
   logic                br_miss;
   logic [31:0]         pc_q, epc_q, cnt_q;
   logic                excp_q, idle_q;
   logic [ECODE_W-1:0]  ecode_q;

   assign accept          = (state_q == RUN) && cmt.cmt_valid_i[0];
   assign cmt.cmt_ready_o = ready;
   assign retire_cnt_o    = cnt_q;
   assign dbg_state       = state_q;

   // Qualify slots in age order; everything younger than the first terminating slot is dropped.
   always_comb begin
      stop      = 1'b0;
      retired   = '0;
      ret_sum   = '0;
      hit_term  = 1'b0;
      hit_excp  = 1'b0;
      hit_idle  = 1'b0;
      hit_ecode = '0;
      hit_pc    = '0;
      hit_tgt   = '0;
      br_found  = 1'b0;
      br_pc     = '0;
      br_tgt    = '0;
      br_miss   = 1'b0;
      for (int i = 0; i < CMT_W; i++) begin
         if (accept && cmt.cmt_valid_i[i] && !stop) begin
            retired[i] = ~cmt.cmt_excp_i[i];
            ret_sum    = ret_sum + 32'(retired[i]);
            if (retired[i] && cmt.cmt_is_br_i[i] && !br_found) begin
               br_found = 1'b1;
               br_pc    = cmt.cmt_pc_i[i];
               br_tgt   = cmt.cmt_target_i[i];
               br_miss  = cmt.cmt_redirect_i[i];
            end
            if (cmt.cmt_excp_i[i] | cmt.cmt_redirect_i[i] | cmt.cmt_flush_i[i] | cmt.cmt_idle_i[i]) begin
               stop      = 1'b1;
               hit_term  = 1'b1;
               hit_excp  = cmt.cmt_excp_i[i];
               hit_idle  = cmt.cmt_idle_i[i];
               hit_ecode = cmt.cmt_ecode_i[i];
               hit_pc    = cmt.cmt_pc_i[i];
               if (cmt.cmt_excp_i[i])
                  hit_tgt = eentry_i;
               else if (cmt.cmt_redirect_i[i])
                  hit_tgt = cmt.cmt_target_i[i];
               else
                  hit_tgt = cmt.cmt_pc_i[i] + 32'd4;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) state_q <= RUN;
      else       state_q <= state_d;
   end

   // Next state and flush/idle outputs decoded from the current state.
   always_comb begin
      state_d       = state_q;
      ready         = 1'b0;
      flush_o       = 1'b0;
      redirect_o    = 1'b0;
      redirect_pc_o = '0;
      excp_valid_o  = 1'b0;
      excp_ecode_o  = '0;
      excp_pc_o     = '0;
      idle_o        = 1'b0;
      case (state_q)
         RUN: begin
            ready = 1'b1;
            if (hit_term) state_d = FLUSH;
         end
         FLUSH: begin
            flush_o       = 1'b1;
            redirect_o    = 1'b1;
            redirect_pc_o = pc_q;
            excp_valid_o  = excp_q;
            if (excp_q) begin
               excp_ecode_o = ecode_q;
               excp_pc_o    = epc_q;
            end
            state_d = (idle_q && !excp_q) ? IDLE : RUN;
         end
         IDLE: begin
            idle_o = 1'b1;
            if (intr_i) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Capture the redirect target and exception details of the terminating slot.
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         pc_q    <= '0;
         epc_q   <= '0;
         excp_q  <= 1'b0;
         idle_q  <= 1'b0;
         ecode_q <= '0;
      end else if (hit_term) begin
         pc_q    <= hit_tgt;
         epc_q   <= hit_pc;
         excp_q  <= hit_excp;
         idle_q  <= hit_idle;
         ecode_q <= hit_ecode;
      end
   end

   // Registered RAT/free-list/BPU updates and the retired-instruction counter.
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         arat_we_o        <= '0;
         arat_areg_o      <= '0;
         arat_preg_o      <= '0;
         free_valid_o     <= '0;
         free_preg_o      <= '0;
         bpu_upd_valid_o  <= 1'b0;
         bpu_upd_pc_o     <= '0;
         bpu_upd_target_o <= '0;
         bpu_upd_miss_o   <= 1'b0;
         cnt_q            <= '0;
      end else begin
         for (int i = 0; i < CMT_W; i++) begin
            if (retired[i] && cmt.cmt_dst_valid_i[i]) begin
               arat_we_o[i]    <= 1'b1;
               arat_areg_o[i]  <= cmt.cmt_areg_i[i];
               arat_preg_o[i]  <= cmt.cmt_preg_i[i];
               free_valid_o[i] <= 1'b1;
               free_preg_o[i]  <= cmt.cmt_old_preg_i[i];
            end else begin
               arat_we_o[i]    <= 1'b0;
               arat_areg_o[i]  <= '0;
               arat_preg_o[i]  <= '0;
               free_valid_o[i] <= 1'b0;
               free_preg_o[i]  <= '0;
            end
         end
         bpu_upd_valid_o  <= br_found;
         bpu_upd_pc_o     <= br_pc;
         bpu_upd_target_o <= br_tgt;
         bpu_upd_miss_o   <= br_miss;
         cnt_q            <= cnt_q + ret_sum;
      end
   end

endmodule

// File: tb/tb_retire_unit.sv
// Bench for retire_unit: directed scenarios plus random bundles, checked by a
// negedge monitor against expected output records queued by the driver.
module tb_retire_unit;

   logic clk = 1'b0;
   logic a_rst;
   logic [31:0] eentry_i;
   logic intr_i;
   logic [1:0]       arat_we_o;
   logic [1:0][4:0]  arat_areg_o;
   logic [1:0][5:0]  arat_preg_o;
   logic [1:0]       free_valid_o;
   logic [1:0][5:0]  free_preg_o;
   logic bpu_upd_valid_o, bpu_upd_miss_o;
   logic [31:0] bpu_upd_pc_o, bpu_upd_target_o;
   logic flush_o, redirect_o, excp_valid_o, idle_o;
   logic [31:0] redirect_pc_o, excp_pc_o, retire_cnt_o;
   logic [5:0] excp_ecode_o;
   logic [1:0] dbg_state;

   retire_unit_if cmt_bus ();

   retire_unit dut (
      .clk(clk), .a_rst(a_rst), .cmt(cmt_bus), .eentry_i(eentry_i), .intr_i(intr_i),
      .arat_we_o(arat_we_o), .arat_areg_o(arat_areg_o), .arat_preg_o(arat_preg_o),
      .free_valid_o(free_valid_o), .free_preg_o(free_preg_o),
      .bpu_upd_valid_o(bpu_upd_valid_o), .bpu_upd_pc_o(bpu_upd_pc_o),
      .bpu_upd_target_o(bpu_upd_target_o), .bpu_upd_miss_o(bpu_upd_miss_o),
      .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
      .excp_valid_o(excp_valid_o), .excp_ecode_o(excp_ecode_o), .excp_pc_o(excp_pc_o),
      .idle_o(idle_o), .retire_cnt_o(retire_cnt_o), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- expected output record ----------------
   typedef struct packed {
      logic ready, idle, flush, redir;
      logic [31:0] rpc;
      logic ev;
      logic [5:0] ec;
      logic [31:0] epc;
      logic [1:0] awe;
      logic [1:0][4:0] aareg;
      logic [1:0][5:0] apreg;
      logic [1:0] fv;
      logic [1:0][5:0] fpreg;
      logic bv;
      logic [31:0] bpc, btgt;
      logic bmiss;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_nxt;
   int checks = 0;
   int failures = 0;

   // Reference model: 0 = running, 1 = flushing, 2 = idle.
   int m_mode;
   logic [31:0] m_cnt, m_pc, m_epc;
   logic m_exc, m_idl;
   logic [5:0] m_ec;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic exp_t reset_rec();
      exp_t r = '0;
      r.ready = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cnt = '0; m_pc = '0; m_epc = '0; m_exc = 1'b0; m_idl = 1'b0; m_ec = '0;
      e_nxt = reset_rec();
   endtask

   // Predict the outputs seen in the cycle after the coming rising edge.
   task automatic model_step();
      exp_t n = '0;
      int nxt = m_mode;
      bit stop = 0;
      if (m_mode == 0) begin
         if (cmt_bus.cmt_valid_i[0]) begin
            for (int i = 0; i < 2; i++) begin
               if (!stop && cmt_bus.cmt_valid_i[i]) begin
                  if (!cmt_bus.cmt_excp_i[i]) begin
                     m_cnt = m_cnt + 1;
                     if (cmt_bus.cmt_dst_valid_i[i]) begin
                        n.awe[i] = 1'b1; n.aareg[i] = cmt_bus.cmt_areg_i[i];
                        n.apreg[i] = cmt_bus.cmt_preg_i[i];
                        n.fv[i] = 1'b1; n.fpreg[i] = cmt_bus.cmt_old_preg_i[i];
                     end
                     if (cmt_bus.cmt_is_br_i[i] && !n.bv) begin
                        n.bv = 1'b1; n.bpc = cmt_bus.cmt_pc_i[i];
                        n.btgt = cmt_bus.cmt_target_i[i]; n.bmiss = cmt_bus.cmt_redirect_i[i];
                     end
                  end
                  if (cmt_bus.cmt_excp_i[i] || cmt_bus.cmt_redirect_i[i] ||
                      cmt_bus.cmt_flush_i[i] || cmt_bus.cmt_idle_i[i]) begin
                     stop = 1;
                     nxt = 1;
                     m_exc = cmt_bus.cmt_excp_i[i];
                     m_idl = cmt_bus.cmt_idle_i[i];
                     m_ec = cmt_bus.cmt_ecode_i[i];
                     m_epc = cmt_bus.cmt_pc_i[i];
                     if (cmt_bus.cmt_excp_i[i]) m_pc = eentry_i;
                     else if (cmt_bus.cmt_redirect_i[i]) m_pc = cmt_bus.cmt_target_i[i];
                     else m_pc = cmt_bus.cmt_pc_i[i] + 32'd4;
                  end
               end
            end
         end
      end else if (m_mode == 1) begin
         nxt = (m_idl && !m_exc) ? 2 : 0;
      end else begin
         nxt = intr_i ? 0 : 2;
      end
      m_mode = nxt;
      n.ready = (nxt == 0);
      n.idle = (nxt == 2);
      if (nxt == 1) begin
         n.flush = 1'b1; n.redir = 1'b1; n.rpc = m_pc;
         n.ev = m_exc;
         if (m_exc) begin n.ec = m_ec; n.epc = m_epc; end
      end
      n.cnt = m_cnt;
      e_nxt = n;
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_in();
      cmt_bus.cmt_valid_i = '0; cmt_bus.cmt_pc_i = '0; cmt_bus.cmt_dst_valid_i = '0;
      cmt_bus.cmt_areg_i = '0; cmt_bus.cmt_preg_i = '0; cmt_bus.cmt_old_preg_i = '0;
      cmt_bus.cmt_excp_i = '0; cmt_bus.cmt_ecode_i = '0; cmt_bus.cmt_redirect_i = '0;
      cmt_bus.cmt_target_i = '0; cmt_bus.cmt_flush_i = '0; cmt_bus.cmt_idle_i = '0;
      cmt_bus.cmt_is_br_i = '0; intr_i = 1'b0; eentry_i = 32'h1c00_8000;
   endtask

   task automatic set_slot(input int i, input logic [31:0] pc, input logic dv,
                           input logic [4:0] ar, input logic [5:0] pr, input logic [5:0] op);
      cmt_bus.cmt_valid_i[i] = 1'b1; cmt_bus.cmt_pc_i[i] = pc; cmt_bus.cmt_dst_valid_i[i] = dv;
      cmt_bus.cmt_areg_i[i] = ar; cmt_bus.cmt_preg_i[i] = pr; cmt_bus.cmt_old_preg_i[i] = op;
   endtask

   // Called at posedge+1 with inputs already driven for this cycle.
   task automatic step();
      exp_q.push_back(e_nxt);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_steps(input int n);
      for (int k = 0; k < n; k++) begin clear_in(); step(); end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      a_rst = 1'b1;
      clear_in();
      #1;
      chk("rst_idle", idle_o, 1'b0);
      chk("rst_ready", cmt_bus.cmt_ready_o, 1'b1);
      chk("rst_flush", {flush_o, excp_valid_o, retire_cnt_o}, '0);
      @(posedge clk);
      #2;
      a_rst = 1'b0;
      exp_q.delete();
      model_reset();
   endtask

   task automatic rand_bundle();
      clear_in();
      cmt_bus.cmt_valid_i[0] = ($urandom_range(0, 3) != 0);
      cmt_bus.cmt_valid_i[1] = cmt_bus.cmt_valid_i[0] && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 2; i++) begin
         cmt_bus.cmt_pc_i[i] = $urandom() & 32'hffff_fffc;
         cmt_bus.cmt_dst_valid_i[i] = 1'($urandom_range(0, 1));
         cmt_bus.cmt_areg_i[i] = 5'($urandom_range(0, 31));
         cmt_bus.cmt_preg_i[i] = 6'($urandom_range(0, 63));
         cmt_bus.cmt_old_preg_i[i] = 6'($urandom_range(0, 63));
         cmt_bus.cmt_excp_i[i] = ($urandom_range(0, 15) == 0);
         cmt_bus.cmt_ecode_i[i] = 6'($urandom_range(0, 63));
         cmt_bus.cmt_redirect_i[i] = ($urandom_range(0, 11) == 0);
         cmt_bus.cmt_target_i[i] = $urandom() & 32'hffff_fffc;
         cmt_bus.cmt_flush_i[i] = ($urandom_range(0, 19) == 0);
         cmt_bus.cmt_idle_i[i] = ($urandom_range(0, 29) == 0);
         cmt_bus.cmt_is_br_i[i] = ($urandom_range(0, 2) == 0);
      end
      intr_i = ($urandom_range(0, 3) == 0);
      eentry_i = $urandom() & 32'hffff_fffc;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("ready", cmt_bus.cmt_ready_o, e.ready);
         chk("idle", idle_o, e.idle);
         chk("flush_redirect", {flush_o, redirect_o}, {e.flush, e.redir});
         if (e.flush) chk("redirect_pc", redirect_pc_o, e.rpc);
         chk("excp_valid", excp_valid_o, e.ev);
         if (e.ev) chk("excp_info", {excp_ecode_o, excp_pc_o}, {e.ec, e.epc});
         chk("arat", {arat_we_o, arat_areg_o, arat_preg_o}, {e.awe, e.aareg, e.apreg});
         chk("free", {free_valid_o, free_preg_o}, {e.fv, e.fpreg});
         chk("bpu_valid", bpu_upd_valid_o, e.bv);
         if (e.bv) chk("bpu_info", {bpu_upd_pc_o, bpu_upd_target_o, bpu_upd_miss_o},
                       {e.bpc, e.btgt, e.bmiss});
         chk("retire_cnt", retire_cnt_o, e.cnt);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      a_rst = 1'b1;
      clear_in();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2;
      a_rst = 1'b0;

      // Two plain ALU slots, accepted on the first edge after reset release.
      clear_in();
      set_slot(0, 32'h1c00_0000, 1'b1, 5'd3, 6'd10, 6'd5);
      set_slot(1, 32'h1c00_0004, 1'b1, 5'd4, 6'd11, 6'd6);
      step();
      idle_steps(2);

      // Slot 0 mispredicted branch; slot 1 must be dropped.
      clear_in();
      set_slot(0, 32'h1c00_0010, 1'b0, 5'd0, 6'd0, 6'd0);
      cmt_bus.cmt_redirect_i[0] = 1'b1; cmt_bus.cmt_is_br_i[0] = 1'b1;
      cmt_bus.cmt_target_i[0] = 32'h1c00_0100;
      set_slot(1, 32'h1c00_0014, 1'b1, 5'd7, 6'd20, 6'd21);
      step();
      idle_steps(2);

      // Slot 0 exception.
      clear_in();
      set_slot(0, 32'h1c00_0020, 1'b1, 5'd9, 6'd30, 6'd31);
      cmt_bus.cmt_excp_i[0] = 1'b1; cmt_bus.cmt_ecode_i[0] = 6'h08;
      eentry_i = 32'h1c00_8000;
      step();
      idle_steps(2);

      // Idle at the top of the address space: pc + 4 wraps to 0, then hold in IDLE.
      clear_in();
      set_slot(0, 32'hffff_fffc, 1'b0, 5'd0, 6'd0, 6'd0);
      cmt_bus.cmt_idle_i[0] = 1'b1;
      step();
      idle_steps(1);
      for (int k = 0; k < 5; k++) begin
         clear_in();
         set_slot(0, 32'h1c00_0040, 1'b1, 5'd1, 6'd2, 6'd3);
         step();
      end
      clear_in(); intr_i = 1'b1; step();
      idle_steps(2);

      // Counter wrap: hold the counter at all-ones across an empty edge, then retire two.
      clear_in();
      force dut.cnt_q = 32'hffff_ffff;
      m_cnt = 32'hffff_ffff;
      e_nxt.cnt = 32'hffff_ffff;
      step();
      release dut.cnt_q;
      clear_in();
      set_slot(0, 32'h1c00_0050, 1'b1, 5'd12, 6'd40, 6'd41);
      set_slot(1, 32'h1c00_0054, 1'b1, 5'd12, 6'd42, 6'd43);
      step();
      idle_steps(2);

      // Reset while in IDLE, then accept immediately after release.
      clear_in();
      set_slot(0, 32'h1c00_0060, 1'b0, 5'd0, 6'd0, 6'd0);
      cmt_bus.cmt_idle_i[0] = 1'b1;
      step();
      idle_steps(3);
      do_reset();
      clear_in();
      set_slot(0, 32'h1c00_0070, 1'b1, 5'd5, 6'd15, 6'd16);
      step();
      idle_steps(1);

      // Randomized bundles.
      for (int k = 0; k < 600; k++) begin
         rand_bundle();
         step();
      end
      idle_steps(3);

      @(negedge clk);
      #1;
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
